mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//   Multi-cycle control FSM for the MIPS datapath; drives the ALU from the issuing side.
//   Decodes op/funct, sequences fetch/decode/execute/memory/writeback, emits ALUctr
//   with mux/write strobes and consumes the ALU Zero flag to resolve beq.
//   Handshakes with a shared instruction/data memory through mem_ready.
// PARAMETERS
//   OP_RTYPE  6'b000000  R-type opcode
//   OP_ORI    6'b001101  ori opcode
//   OP_LW     6'b100011  lw opcode
//   OP_SW     6'b101011  sw opcode
//   OP_BEQ    6'b000100  beq opcode
//   OP_J      6'b000010  j opcode
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   op         in   6  IR[31:26], valid from DECODE on
//   funct      in   6  IR[5:0]
//   Zero       in   1  ALU zero flag (combinational from the ALU)
//   mem_ready  in   1  memory done; read data valid / write accepted this cycle
//   ALUctr     out  3  000 add, 001 addu, 010 sub, 011 subu, 100 or
//   ALUSrcA    out  1  0 = PC, 1 = reg A
//   ALUSrcB    out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
//   ExtOp      out  1  1 = sign-extend imm, 0 = zero-extend
//   PCWr       out  1  PC write enable
//   PCSrc      out  2  00 ALU result, 01 ALUOut reg, 10 {PC[31:28],IR[25:0],2'b00}
//   IRWr       out  1  instruction register write enable
//   MemRd      out  1  memory read request; IorD = 0 in FETCH, 1 in MEM_RD
//   IorD       out  1  address select: 0 PC, 1 ALUOut
//   MemWr      out  1  memory write request
//   RegWr      out  1  register file write enable
//   RegDst     out  1  1 = rd, 0 = rt
//   MemtoReg   out  1  1 = MDR, 0 = ALUOut
//   illegal    out  1  sticky; unsupported op/funct decoded
//   state      out  4  current state, for debug
// BEHAVIOUR
//   - Moore outputs, decoded from state. Exception: PCWr in BRANCH equals Zero.
//   - States: IDLE=0 FETCH=1 DECODE=2 EXE=3 MEM_RD=4 MEM_WR=5 WB_ALU=6 WB_MEM=7
//     BRANCH=8 JUMP=9 TRAP=15.
//   - Reset: state=IDLE; all outputs 0, except ALUctr=001 and ExtOp=1.
//     IDLE drives the same values. IDLE -> FETCH unconditionally on the next edge.
//   - FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=001, PCSrc=00.
//     IRWr=PCWr=mem_ready. Stay in FETCH while !mem_ready; else go to DECODE.
//   - DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=001 (branch target to ALUOut).
//     Next state: R-type/ori/lw/sw -> EXE; beq -> BRANCH; j -> JUMP; other -> TRAP.
//     R-type funct outside {100000,100001,100010,100011} -> TRAP.
//   - EXE, R-type: ALUSrcA=1, ALUSrcB=00, ALUctr=funct[1:0]?{0,funct[1:0]}
//     (add 000, addu 001, sub 010, subu 011). Next state WB_ALU, RegDst=1.
//   - EXE, ori: ALUSrcB=10, ExtOp=0, ALUctr=100. Next state WB_ALU, RegDst=0.
//   - EXE, lw/sw: ALUSrcB=10, ExtOp=1, ALUctr=001. Next state MEM_RD or MEM_WR.
//   - MEM_RD: MemRd=1, IorD=1. Hold while !mem_ready; then WB_MEM.
//   - MEM_WR: MemWr=1, IorD=1. Hold while !mem_ready; then FETCH.
//   - WB_ALU: RegWr=1, MemtoReg=0, RegDst per the op. Next state FETCH.
//   - WB_MEM: RegWr=1, MemtoReg=1, RegDst=0. Next state FETCH.
//   - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUctr=011, PCSrc=01, PCWr=Zero. Next state FETCH.
//   - JUMP: PCSrc=10, PCWr=1. Next state FETCH.
//   - TRAP: illegal=1, all strobes 0. Stays in TRAP until reset.
//   - Latency with mem_ready always 1: R/ori 4 cycles, lw 5, sw 4, beq 3, j 3.
//     Each cycle mem_ready is low in FETCH/MEM_RD/MEM_WR adds one cycle.
//   - Strobe hold: MemRd/MemWr stay asserted and stable throughout a wait. Exactly one
//     RegWr pulse per R/ori/lw instruction. Never a RegWr and MemWr pulse together.
//   - Reset mid-instruction: state goes to IDLE asynchronously and strobes drop at once.
//     No partial writeback is issued after reset is released.
// TESTING
//   - Reset mid-MEM_WR, mem_ready=1: MemWr drops without a clock, illegal clears;
//     IDLE then FETCH after release.
//   - addu (op 0, funct 100001), mem_ready=1: states 1,2,3,6. ALUctr=001 in EXE.
//     RegWr=1, RegDst=1 in cycle 4 only.
//   - lw, mem_ready low 2 cycles in MEM_RD: 7 cycles total. MemRd held 3 cycles.
//     RegWr with MemtoReg=1 once.
//   - beq with Zero=1: PCWr=1, PCSrc=01 in BRANCH. Repeat with Zero=0: PCWr stays 0.
//     3 cycles each.
//   - ori: ALUctr=100, ExtOp=0, ALUSrcB=10 in EXE. WB with RegDst=0.
//   - op=6'b111111: TRAP after DECODE, illegal=1, no further PCWr/MemRd.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM.
// Sequences fetch/decode/execute/memory/writeback around a shared memory.
module mc_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_ORI   = 6'b001101,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [2:0] ALUctr,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       PCWr,
  output logic [1:0] PCSrc,
  output logic       IRWr,
  output logic       MemRd,
  output logic       IorD,
  output logic       MemWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXE    = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_ALU = 4'd6,
    S_WB_MEM = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd15
  } state_t;

  state_t     r_state;
  state_t     w_dec_next;
  logic       r_rtype;
  logic       r_ori;
  logic       r_lw;
  logic [1:0] r_alu;

  logic w_is_r;
  logic w_is_ori;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_j;
  logic w_funct_ok;

  assign w_is_r     = (op == OP_RTYPE);
  assign w_is_ori   = (op == OP_ORI);
  assign w_is_lw    = (op == OP_LW);
  assign w_is_sw    = (op == OP_SW);
  assign w_is_beq   = (op == OP_BEQ);
  assign w_is_j     = (op == OP_J);
  // add/addu/sub/subu are 1000xx
  assign w_funct_ok = (funct[5:2] == 4'b1000);

  always_comb begin
    w_dec_next = S_TRAP;
    unique case (1'b1)
      w_is_r:   w_dec_next = w_funct_ok ? S_EXE : S_TRAP;
      w_is_ori: w_dec_next = S_EXE;
      w_is_lw:  w_dec_next = S_EXE;
      w_is_sw:  w_dec_next = S_EXE;
      w_is_beq: w_dec_next = S_BRANCH;
      w_is_j:   w_dec_next = S_JUMP;
      default:  w_dec_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rtype <= 1'b0;
      r_ori   <= 1'b0;
      r_lw    <= 1'b0;
      r_alu   <= 2'b00;
    end else begin
      unique case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_rtype <= w_is_r;
          r_ori   <= w_is_ori;
          r_lw    <= w_is_lw;
          r_alu   <= funct[1:0];
          r_state <= w_dec_next;
        end
        S_EXE: begin
          if (r_rtype || r_ori) r_state <= S_WB_ALU;
          else if (r_lw)        r_state <= S_MEM_RD;
          else                  r_state <= S_MEM_WR;
        end
        S_MEM_RD: if (mem_ready) r_state <= S_WB_MEM;
        S_MEM_WR: if (mem_ready) r_state <= S_FETCH;
        S_WB_ALU: r_state <= S_FETCH;
        S_WB_MEM: r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so reset kills them immediately
  always_comb begin
    ALUctr   = 3'b001;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ExtOp    = 1'b1;
    PCWr     = 1'b0;
    PCSrc    = 2'b00;
    IRWr     = 1'b0;
    MemRd    = 1'b0;
    IorD     = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        MemRd   = 1'b1;
        ALUSrcB = 2'b01;
        IRWr    = mem_ready;
        PCWr    = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_EXE: begin
        ALUSrcA = 1'b1;
        if (r_rtype) begin
          ALUSrcB = 2'b00;
          ALUctr  = {1'b0, r_alu};
        end else if (r_ori) begin
          ALUSrcB = 2'b10;
          ExtOp   = 1'b0;
          ALUctr  = 3'b100;
        end else begin
          ALUSrcB = 2'b10;
        end
      end
      S_MEM_RD: begin
        MemRd = 1'b1;
        IorD  = 1'b1;
      end
      S_MEM_WR: begin
        MemWr = 1'b1;
        IorD  = 1'b1;
      end
      S_WB_ALU: begin
        RegWr  = 1'b1;
        RegDst = r_rtype;
      end
      S_WB_MEM: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUctr  = 3'b011;
        PCSrc   = 2'b01;
        PCWr    = Zero;
      end
      S_JUMP: begin
        PCSrc = 2'b10;
        PCWr  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = (r_state == S_TRAP);
  assign state   = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed plus randomized instructions
// against a phase-list model of the instruction flow.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] ALUctr;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic       PCWr;
  logic [1:0] PCSrc;
  logic       IRWr;
  logic       MemRd;
  logic       IorD;
  logic       MemWr;
  logic       RegWr;
  logic       RegDst;
  logic       MemtoReg;
  logic       illegal;
  logic [3:0] state;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
    .Zero(Zero), .mem_ready(mem_ready),
    .ALUctr(ALUctr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtOp(ExtOp), .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr),
    .MemRd(MemRd), .IorD(IorD), .MemWr(MemWr), .RegWr(RegWr),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DEC = 2, ST_EXE = 3;
  localparam int ST_MRD = 4, ST_MWR = 5, ST_WBA = 6, ST_WBM = 7;
  localparam int ST_BR = 8, ST_JMP = 9, ST_TRAP = 15;
  localparam int K_R = 0, K_ORI = 1, K_LW = 2, K_SW = 3;
  localparam int K_BEQ = 4, K_J = 5;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] op_of(input int k);
    case (k)
      K_R:     return 6'b000000;
      K_ORI:   return 6'b001101;
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_BEQ:   return 6'b000100;
      default: return 6'b000010;
    endcase
  endfunction

  // Entered at posedge+1 with the DUT in FETCH; leaves at the next FETCH.
  task automatic run_instr(input int k, input logic [5:0] f,
                           input logic z, input int wf, input int wm);
    int st_q[$];
    bit mr_q[$];
    int n_regwr = 0, n_memwr = 0, n_memrd = 0, n_pcwr = 0, n_irwr = 0;
    int e_memrd, e_memwr, e_pcwr, e_regwr;
    for (int i = 0; i <= wf; i++) begin
      st_q.push_back(ST_FETCH);
      mr_q.push_back(i == wf);
    end
    st_q.push_back(ST_DEC); mr_q.push_back(1'($urandom));
    case (k)
      K_R, K_ORI: begin
        st_q.push_back(ST_EXE); mr_q.push_back(1'($urandom));
        st_q.push_back(ST_WBA); mr_q.push_back(1'($urandom));
      end
      K_LW, K_SW: begin
        st_q.push_back(ST_EXE); mr_q.push_back(1'($urandom));
        for (int i = 0; i <= wm; i++) begin
          st_q.push_back(k == K_LW ? ST_MRD : ST_MWR);
          mr_q.push_back(i == wm);
        end
        if (k == K_LW) begin
          st_q.push_back(ST_WBM); mr_q.push_back(1'($urandom));
        end
      end
      K_BEQ: begin
        st_q.push_back(ST_BR); mr_q.push_back(1'($urandom));
      end
      default: begin
        st_q.push_back(ST_JMP); mr_q.push_back(1'($urandom));
      end
    endcase
    e_memrd = wf + 1 + (k == K_LW ? wm + 1 : 0);
    e_memwr = (k == K_SW) ? wm + 1 : 0;
    e_pcwr  = 1 + ((k == K_BEQ && z) ? 1 : 0) + (k == K_J ? 1 : 0);
    e_regwr = (k == K_R || k == K_ORI || k == K_LW) ? 1 : 0;
    op = op_of(k);
    funct = f;
    Zero = z;
    foreach (st_q[i]) begin
      mem_ready = mr_q[i];
      #1;
      chk($sformatf("state k%0d c%0d", k, i), state, st_q[i]);
      n_regwr += int'(RegWr);
      n_memwr += int'(MemWr);
      n_memrd += int'(MemRd);
      n_pcwr  += int'(PCWr);
      n_irwr  += int'(IRWr);
      if (st_q[i] == ST_EXE) begin
        chk("exe_aluctr", ALUctr,
            k == K_R ? {1'b0, f[1:0]} : (k == K_ORI ? 3'b100 : 3'b001));
        chk("exe_srcb", ALUSrcB, k == K_R ? 2'b00 : 2'b10);
        if (k != K_R) chk("exe_extop", ExtOp, k != K_ORI);
      end
      if (RegWr) begin
        chk("wb_regdst", RegDst, k == K_R);
        chk("wb_memtoreg", MemtoReg, k == K_LW);
      end
      if (st_q[i] == ST_BR) chk("br_pcsrc", PCSrc, 2'b01);
      if (st_q[i] == ST_JMP) chk("j_pcsrc", PCSrc, 2'b10);
      @(posedge clk); #1;
    end
    chk("n_regwr", n_regwr, e_regwr);
    chk("n_memwr", n_memwr, e_memwr);
    chk("n_memrd", n_memrd, e_memrd);
    chk("n_pcwr", n_pcwr, e_pcwr);
    chk("n_irwr", n_irwr, 1);
  endtask

  task automatic reset_and_start();
    rst_n = 1'b0;
    #1;
    chk("rst_state", state, ST_IDLE);
    chk("rst_illegal", illegal, 0);
    chk("rst_memwr", MemWr, 0);
    chk("rst_memrd", MemRd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_idle", state, ST_IDLE);
    @(posedge clk); #1;
    chk("rel_fetch", state, ST_FETCH);
  endtask

  task automatic trap_run(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    mem_ready = 1'b1;
    #1;
    chk("trap_fetch", state, ST_FETCH);
    @(posedge clk); #1;
    chk("trap_decode", state, ST_DEC);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom);
      #1;
      chk("trap_state", state, ST_TRAP);
      chk("trap_illegal", illegal, 1);
      chk("trap_pcwr", PCWr, 0);
      chk("trap_memrd", MemRd, 0);
      chk("trap_regwr", RegWr, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #12;
    chk("reset_state", state, ST_IDLE);
    chk("reset_aluctr", ALUctr, 3'b001);
    chk("reset_extop", ExtOp, 1);
    chk("reset_strobes",
        {ALUSrcA, ALUSrcB, PCWr, PCSrc, IRWr, MemRd, IorD,
         MemWr, RegWr, RegDst, MemtoReg, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_fetch", state, ST_FETCH);

    run_instr(K_R, 6'b100001, 1'b0, 0, 0);
    run_instr(K_LW, 6'b000000, 1'b0, 0, 2);
    run_instr(K_BEQ, 6'b000000, 1'b1, 0, 0);
    run_instr(K_BEQ, 6'b000000, 1'b0, 0, 0);
    run_instr(K_ORI, 6'b000000, 1'b0, 0, 0);
    run_instr(K_SW, 6'b000000, 1'b0, 1, 1);
    run_instr(K_J, 6'b000000, 1'b1, 2, 0);

    for (int n = 0; n < 40; n++) begin
      int k;
      logic [5:0] f;
      k = int'($urandom_range(0, 5));
      f = {4'b1000, 2'($urandom)};
      run_instr(k, f, 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)));
    end

    // Reset while a store is being accepted
    op = 6'b101011;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mwr_reached", state, ST_MWR);
    chk("mwr_memwr", MemWr, 1);
    reset_and_start();

    trap_run(6'b111111, 6'b000000);
    reset_and_start();
    trap_run(6'b000000, 6'b100100);
    reset_and_start();
    run_instr(K_R, 6'b100010, 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
